tdm_demux4_8bit: RTL
====================

// Module: tdm_demux4_8bit
// PURPOSE
//   Receive end of a 4-channel time-division link: one shared 8-bit word stream
//   (channel 0,1,2,3, repeating) is split back into four parallel channel outputs.
//   Words are staged per channel. All four outputs update together once a full
//   frame is captured. Sits after the 4:1 selector path that serialises channels.
// PARAMETERS
//   WIDTH        8   data word width (all data ports)
//   REQUIRE_SOF  1   1: start in HUNT and lock on in_sof; 0: start LOCKED at ch 0
// PORTS
//   clk          in   1      system clock, all logic on rising edge
//   rst          in   1      synchronous reset, active-high
//   in_valid     in   1      in_data carries a word this cycle
//   in_data      in   WIDTH  serial channel word
//   in_sof       in   1      qualified by in_valid: this word is channel 0
//   out0..out3   out  WIDTH  registered channel words of last complete frame
//   frame_valid  out  1      1-cycle pulse: out0..out3 just updated
//   chan         out  2      channel index the next accepted word goes to
//   locked       out  1      1 in LOCKED state
//   sync_err     out  1      1-cycle pulse: in_sof arrived mid-frame
// BEHAVIOUR
//   Reset (rst=1 at edge): out0..out3=0, frame_valid=0, sync_err=0, chan=0,
//     staging regs=0, state=HUNT (REQUIRE_SOF=1) or LOCKED (REQUIRE_SOF=0).
//   in_sof with in_valid=0 is ignored. in_data is ignored when in_valid=0.
//   No backpressure: a word is accepted on every cycle with in_valid=1.
//   HUNT: locked=0, chan holds 0.
//     Word without sof -> dropped.
//     Word with sof -> stage[0]<=in_data, chan<=1, go LOCKED.
//   LOCKED: locked=1.
//     Word at chan 0..2 without sof -> stage[chan]<=in_data, chan<=chan+1.
//     Word at chan=3 without sof -> out0..2<=stage[0..2], out3<=in_data,
//       chan<=0 (wrap), frame_valid=1 next cycle.
//     Word with sof, chan=0 -> normal channel-0 capture, no error.
//     Word with sof, chan!=0 -> partial frame discarded, outputs unchanged.
//       sync_err=1 next cycle. stage[0]<=in_data, chan<=1 (realign).
//     sof on the chan=3 word is a realign: no frame completes.
//   Latency: outputs and frame_valid change at the edge that accepts the ch3
//     word and are visible the following cycle. Back-to-back frames give
//     frame_valid every 4th cycle, at most.
//   Outputs hold between frames. Partially staged words never reach out*.
//   frame_valid and sync_err never assert in the same cycle.
//   Reset mid-frame: staging discarded, outputs cleared, state as at reset.
//     A word presented together with rst=1 is dropped.
//   chan arithmetic is 2-bit modulo-4. No other counter exists.
// TESTING
//   1 rst, then words 11,22(sof on 11),33,44 with in_valid=1 -> next cycle
//     out0..3=11,22,33,44, frame_valid=1 for exactly 1 cycle, chan=0.
//   2 In HUNT: words AA,BB without sof -> dropped; locked=0, outputs stay 0.
//     Then sof+01 -> locked=1 on the next cycle.
//   3 Locked. Send 01,02, then sof+05,06,07,08 -> sync_err pulse after 05,
//     then out=05,06,07,08. Prior outputs held until then.
//   4 Gaps: frame 10,20,30,40 with in_valid low 3 cycles between words ->
//     same single frame_valid, outputs correct, chan steps only on valid.
//   5 Two back-to-back frames at full rate -> frame_valid on cycles 4 and 8
//     after the first word; second frame replaces all four outputs at once.
//   6 rst asserted after 2 words of a frame -> all outputs 0, locked=0.
//     A following frame without a leading sof produces no frame_valid.

Source files
------------

// File: rtl/tdm_demux4_8bit.sv
// tdm_demux4_8bit
// Receive side of a 4-channel TDM link. Serial words arrive as ch0..ch3 and
// are collected per channel. All four parallel outputs update together when
// the channel-3 word of a clean frame is accepted. In HUNT the block waits for
// an in_sof word. Once LOCKED, an in_sof that arrives mid-frame discards the
// partial frame and realigns the channel count to that word.
//
// state  | meaning
// HUNT   | not aligned; words without in_sof are dropped
// LOCKED | aligned; r_chan selects the channel for the next accepted word

module tdm_demux4_8bit #(
    parameter int WIDTH       = 8,
    parameter int REQUIRE_SOF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic [1:0]       chan,
    output logic             locked,
    output logic             sync_err
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Without REQUIRE_SOF the block trusts the link to start on channel 0.
    localparam logic [0:0] ST_RESET  = (REQUIRE_SOF != 0) ? ST_HUNT : ST_LOCKED;

    logic [0:0]       r_state;
    logic [1:0]       r_chan;
    logic [WIDTH-1:0] r_stage0;
    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;
    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;
    logic [WIDTH-1:0] r_out2;
    logic [WIDTH-1:0] r_out3;
    logic             r_frame_valid;
    logic             r_sync_err;

    logic             w_sof_word;
    logic             w_data_word;

    // Classify the incoming word; in_sof only counts alongside in_valid.
    always_comb begin
        w_sof_word  = in_valid & in_sof;
        w_data_word = in_valid & ~in_sof;
    end

    // Alignment FSM, channel counter, staging and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RESET;
            r_chan        <= 2'd0;
            r_stage0      <= '0;
            r_stage1      <= '0;
            r_stage2      <= '0;
            r_out0        <= '0;
            r_out1        <= '0;
            r_out2        <= '0;
            r_out3        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_sof_word) begin
                        r_stage0 <= in_data;
                        r_chan   <= 2'd1;
                        r_state  <= ST_LOCKED;
                    end
                end
                default: begin
                    if (w_sof_word) begin
                        // Start of frame always realigns; it is only an
                        // error when a partial frame is being thrown away.
                        r_stage0   <= in_data;
                        r_chan     <= 2'd1;
                        r_sync_err <= (r_chan != 2'd0);
                    end else if (w_data_word) begin
                        case (r_chan)
                            2'd0: r_stage0 <= in_data;
                            2'd1: r_stage1 <= in_data;
                            2'd2: r_stage2 <= in_data;
                            default: begin
                                r_out0        <= r_stage0;
                                r_out1        <= r_stage1;
                                r_out2        <= r_stage2;
                                r_out3        <= in_data;
                                r_frame_valid <= 1'b1;
                            end
                        endcase
                        r_chan <= r_chan + 2'd1;
                    end
                end
            endcase
        end
    end

    // Drive the ports directly from their registers.
    always_comb begin
        out0        = r_out0;
        out1        = r_out1;
        out2        = r_out2;
        out3        = r_out3;
        frame_valid = r_frame_valid;
        sync_err    = r_sync_err;
        chan        = r_chan;
        locked      = (r_state == ST_LOCKED);
    end

endmodule
